// File: rtl/crt_pkg.sv
// crt_pkg: shared constants and FSM state type for the CRT beam renderer.
package crt_pkg;
  localparam int X_W        = 12;
  localparam int X_INIT     = 1;
  localparam int SAMPLE_COL = 19;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/crt_beam_counter.sv
// crt_beam_counter: ROM address, column and row counters with row wrap and last-pixel flag.
module crt_beam_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic [7:0]        i_w,
  input  logic [7:0]        i_h,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_col,
  output logic [7:0]        o_row,
  output logic              o_last
);
  logic w_col_end;
  assign w_col_end = o_col == i_w - 8'd1;
  assign o_last    = w_col_end && (o_row == i_h - 8'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clr) begin
      o_addr <= '0;
      o_col  <= '0;
      o_row  <= '0;
    end else if (i_adv) begin
      o_addr <= o_addr + ADDR_W'(1);
      o_col  <= w_col_end ? 8'd0 : o_col + 8'd1;
      o_row  <= w_col_end ? o_row + 8'd1 : o_row;
    end
  end
endmodule

// File: rtl/crt_beam_renderer.sv
// crt_beam_renderer: walks the X-delta ROM, accumulates X and streams lit/dark pixels row-major.
// Optional SIGNAL_STRENGTH_EN builds the sampled-column signal-strength accumulator.
module crt_beam_renderer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int X_W    = crt_pkg::X_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [7:0]        screen_w,
  input  logic [7:0]        screen_h,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_on,
  output logic [7:0]        pix_col,
  output logic [7:0]        pix_row,
  output logic [X_W-1:0]    x_reg,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       signal_sum
);
  import crt_pkg::*;
  state_t           r_state, w_next;
  logic             w_start, w_acc, w_last;
  logic [X_W-1:0]   w_delta, w_diff;
  assign w_start = start && (r_state != RUN);
  assign w_acc   = pix_valid && pix_ready;
  assign w_delta = {{(X_W-DATA_W){rom_data[DATA_W-1]}}, rom_data};
  assign w_diff  = x_reg - {{(X_W-8){1'b0}}, pix_col};
  crt_beam_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_adv  (w_acc),
    .i_w    (screen_w),
    .i_h    (screen_h),
    .o_addr (rom_addr),
    .o_col  (pix_col),
    .o_row  (pix_row),
    .o_last (w_last)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_start)
      w_next = (screen_w == 8'd0 || screen_h == 8'd0) ? DONE : RUN;
    else if (r_state == RUN && w_acc && w_last)
      w_next = DONE;
  end
  always_comb begin
    busy       = r_state == RUN;
    pix_valid  = r_state == RUN;
    frame_done = r_state == DONE;
  end
  // Lit when the beam is within one column of X (signed difference -1, 0 or +1).
  assign pix_on = (w_diff == '0) || (w_diff == X_W'(1)) || (w_diff == '1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_start) x_reg <= X_W'(X_INIT);
    else if (w_acc)     x_reg <= x_reg + w_delta;
  end
`ifdef SIGNAL_STRENGTH_EN
  logic [31:0] r_sum, w_cyc, w_x;
  assign w_cyc = 32'(rom_addr) + 32'd1;
  assign w_x   = {{(32-X_W){x_reg[X_W-1]}}, x_reg};
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_start)                          r_sum <= '0;
    else if (w_acc && pix_col == 8'(SAMPLE_COL)) r_sum <= r_sum + w_cyc * w_x;
  end
  assign signal_sum = r_sum;
`else
  assign signal_sum = '0;
`endif
endmodule

// File: tb/tb_crt_beam_renderer.sv
// tb_crt_beam_renderer: directed-vector bench for crt_beam_renderer with a combinational ROM model.
module tb_crt_beam_renderer;
  logic        clk = 0, rst = 1, start = 0, pix_ready = 1;
  logic [7:0]  rom_addr, rom_data, pix_col, pix_row;
  logic [7:0]  screen_w = 8'd40, screen_h = 8'd6;
  logic        pix_valid, pix_on, busy, frame_done;
  logic [11:0] x_reg;
  logic [31:0] signal_sum;
  logic [7:0]  rom_mem [256];
  int          n_chk = 0, n_bad = 0;
  assign rom_data = rom_mem[rom_addr];
  always #5 clk = ~clk;
  crt_beam_renderer dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .screen_w(screen_w), .screen_h(screen_h), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_on(pix_on), .pix_col(pix_col), .pix_row(pix_row), .x_reg(x_reg), .busy(busy),
    .frame_done(frame_done), .signal_sum(signal_sum)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask
  task automatic load_rom(input bit real_rom);
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'd0;
    if (real_rom) begin
      rom_mem[1] = 8'd2; rom_mem[3] = 8'd3; rom_mem[7] = 8'hFB; rom_mem[50] = 8'd9;
    end
  endtask
  // Runs to frame end, counting accepted pixels and (optionally) lit-pattern errors vs cols 0..2.
  task automatic run_rest(input bit lit_chk, output int n, output int errs);
    int b;
    n = 0; errs = 0; b = 0;
    while (!frame_done && b < 2000) begin
      if (pix_valid && pix_ready) begin
        n++;
        if (lit_chk && pix_on != (pix_col < 8'd3)) errs++;
      end
      step(); b++;
    end
    chk("frame_done_reached", {31'd0, frame_done}, 32'd1);
  endtask
  initial begin
    int n, errs;
    bit exp_on [5] = '{1, 1, 1, 1, 0};
    int exp_x  [4] = '{1, 3, 3, 6};
    load_rom(1);
    step(); step();
    rst = 0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_valid", {31'd0, pix_valid}, 0);
    chk("rst_x", {20'd0, x_reg}, 1);
    chk("rst_addr", {24'd0, rom_addr}, 0);
    chk("rst_sum", signal_sum, 0);
    // 1: real ROM full frame
    pulse_start();
    chk("t1_valid", {31'd0, pix_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_on%0d", i), {31'd0, pix_on}, {31'd0, exp_on[i]});
      step();
      if (i < 4) chk($sformatf("t1_x%0d", i), {20'd0, x_reg}, exp_x[i]);
    end
    run_rest(0, n, errs);
    chk("t1_pixels", n + 5, 240);
    chk("t1_valid_off", {31'd0, pix_valid}, 0);
    // 6a: start in DONE re-inits
    pulse_start();
    chk("t6_x_init", {20'd0, x_reg}, 1);
    chk("t6_sum_clr", signal_sum, 0);
    chk("t6_busy", {31'd0, busy}, 1);
    // 3: stall at pixel 3, with an ignored start during RUN
    step(); step(); step();
    pix_ready = 0;
    for (int i = 0; i < 5; i++) step();
    chk("t3_addr", {24'd0, rom_addr}, 3);
    chk("t3_x", {20'd0, x_reg}, 3);
    chk("t3_col", {24'd0, pix_col}, 3);
    chk("t3_on", {31'd0, pix_on}, 1);
    pulse_start();
    chk("t6_run_start_x", {20'd0, x_reg}, 3);
    chk("t6_run_start_addr", {24'd0, rom_addr}, 3);
    pix_ready = 1;
    step();
    chk("t3_resume_x", {20'd0, x_reg}, 6);
    run_rest(0, n, errs);
    chk("t3_pixels", n, 236);
    // 2: all-zero ROM
    load_rom(0);
    pulse_start();
    run_rest(1, n, errs);
    chk("t2_pixels", n, 240);
    chk("t2_lit_errs", errs, 0);
`ifdef SIGNAL_STRENGTH_EN
    chk("t2_sum", signal_sum, 720);
`else
    chk("t2_sum", signal_sum, 0);
`endif
    // 4: negative delta
    rom_mem[0] = 8'hFD;
    pulse_start();
    chk("t4_on_col0", {31'd0, pix_on}, 1);
    step();
    chk("t4_x", {20'd0, x_reg}, 32'h0000_0FFE);
    chk("t4_col1", {24'd0, pix_col}, 1);
    chk("t4_on_col1", {31'd0, pix_on}, 0);
    step();
    chk("t4_on_col2", {31'd0, pix_on}, 0);
    // 5: reset mid-frame
    load_rom(1);
    for (int i = 0; i < 98; i++) step();
    chk("t5_addr100", {24'd0, rom_addr}, 100);
    rst = 1;
    step();
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_x", {20'd0, x_reg}, 1);
    chk("t5_done", {31'd0, frame_done}, 0);
    chk("t5_addr", {24'd0, rom_addr}, 0);
    rst = 0;
    pulse_start();
    run_rest(0, n, errs);
    chk("t5_pixels", n, 240);
    // 6b: zero height
    screen_h = 8'd0;
    pulse_start();
    chk("t6_h0_done", {31'd0, frame_done}, 1);
    chk("t6_h0_valid", {31'd0, pix_valid}, 0);
    chk("t6_h0_busy", {31'd0, busy}, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
